// File: rtl/stream_hub_pkg.sv
// stream_hub_pkg: shared FSM state type and index-width helper for the stream arbiter hub
package stream_hub_pkg;
    typedef enum logic {ARB = 1'b0, ACCEPT = 1'b1} arb_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/stream_hub_fifo.sv
// stream_hub_fifo: synchronous FIFO with power-of-two depth and asynchronous active-low reset
module stream_hub_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    // Storage is cleared too so the head word reads 0 straight out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/stream_arbiter_hub.sv
// stream_arbiter_hub: round-robin N-to-1 stream concentrator with buffered, channel-tagged output.
// Define STREAM_HUB_EXC_CAPTURE_EN for a sticky exception with first-source capture.
module stream_arbiter_hub
    import stream_hub_pkg::*;
#(
    parameter int                  CHANNELS   = 4,
    parameter int                  WIDTH      = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [CHANNELS-1:0] EXC_MASK   = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_stb,
    output logic [CHANNELS-1:0]         in_ack,
    output logic [WIDTH-1:0]            out_data,
    output logic [idx_w(CHANNELS)-1:0]  out_channel,
    output logic                        out_stb,
    input  logic                        out_ack,
    input  logic [CHANNELS-1:0]         exception_in,
    input  logic                        exception_clr,
    output logic                        exception,
    output logic [idx_w(CHANNELS)-1:0]  exception_src
);
    localparam int CW = idx_w(CHANNELS);
    typedef struct packed {
        logic [CW-1:0]    channel;
        logic [WIDTH-1:0] data;
    } entry_t;
    arb_state_t state;
    logic [CW-1:0] grant, last_grant, nxt, c;
    logic full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    entry_t push_entry, head;
    logic [CHANNELS-1:0] masked;
    // Descending scan so the requester closest after last_grant wins
    always_comb begin
        nxt = last_grant;
        c = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            c = CW'((int'(last_grant) + i) % CHANNELS);
            nxt = in_stb[c] ? c : nxt;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            grant <= '0;
            last_grant <= CW'(CHANNELS - 1);
            in_ack <= '0;
        end else if (state == ARB) begin
            if (!full && |in_stb) begin
                grant <= nxt;
                in_ack <= CHANNELS'(1) << nxt;
                state <= ACCEPT;
            end
        end else begin
            in_ack <= '0;
            last_grant <= grant;
            state <= ARB;
        end
    end
    assign push_entry.channel = grant;
    assign push_entry.data = in_data[int'(grant)*WIDTH +: WIDTH];
    stream_hub_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == ACCEPT),
        .pop   (out_ack && !empty),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign out_stb = count != '0;
    assign out_data = head.data;
    assign out_channel = head.channel;
    assign masked = exception_in & EXC_MASK;
`ifdef STREAM_HUB_EXC_CAPTURE_EN
    logic [CW-1:0] low;
    always_comb begin
        low = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) low = masked[i] ? CW'(i) : low;
    end
    // A new fault arriving with the clear re-arms with the new source
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exception <= 1'b0;
            exception_src <= '0;
        end else if (|masked && (!exception || exception_clr)) begin
            exception <= 1'b1;
            exception_src <= low;
        end else if (exception_clr) begin
            exception <= 1'b0;
            exception_src <= '0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = exception_clr;
    assign exception_src = '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exception <= 1'b0;
        else exception <= |masked;
    end
`endif
endmodule

// File: tb/tb_stream_arbiter_hub.sv
// tb_stream_arbiter_hub: directed table-driven bench for stream_arbiter_hub (4 channels, 32-bit, depth 4).
module tb_stream_arbiter_hub;
    localparam int CH = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0] in_stb = '0;
    logic [CH-1:0] in_ack;
    logic [W-1:0] out_data;
    logic [1:0] out_channel;
    logic out_stb;
    logic out_ack = 1'b0;
    logic [CH-1:0] exception_in = '0;
    logic exception_clr = 1'b0;
    logic exception;
    logic [1:0] exception_src;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stream_arbiter_hub #(.CHANNELS(CH), .WIDTH(W), .FIFO_DEPTH(4), .EXC_MASK(4'b1110)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_stb        (in_stb),
        .in_ack        (in_ack),
        .out_data      (out_data),
        .out_channel   (out_channel),
        .out_stb       (out_stb),
        .out_ack       (out_ack),
        .exception_in  (exception_in),
        .exception_clr (exception_clr),
        .exception     (exception),
        .exception_src (exception_src)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_ch;
        logic [31:0] exp_data;
    } sw_vec_t;

    typedef struct {
        logic [3:0] exc;
        logic       exp;
    } exc_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ack"}, in_ack, 0);
        chk({tag, "_out_stb"}, out_stb, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_channel"}, out_channel, 0);
        chk({tag, "_exception"}, exception, 0);
        chk({tag, "_exception_src"}, exception_src, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sw_vec_t sw[4];
        exc_vec_t ev[7];
        int q[$];
        int multi;
        int acks;
        logic prev;
        sw[0] = '{2, 32'hDEADBEEF, 4'b0100, 2'd2, 32'hDEADBEEF};
        sw[1] = '{0, 32'h0000_0001, 4'b0001, 2'd0, 32'h0000_0001};
        sw[2] = '{1, 32'hA5A5_5A5A, 4'b0010, 2'd1, 32'hA5A5_5A5A};
        sw[3] = '{3, 32'hFFFF_FFFF, 4'b1000, 2'd3, 32'hFFFF_FFFF};
        ev[0] = '{4'b0001, 1'b0};
        ev[1] = '{4'b1000, 1'b1};
        ev[2] = '{4'b0000, 1'b0};
        ev[3] = '{4'b0010, 1'b1};
        ev[4] = '{4'b0111, 1'b1};
        ev[5] = '{4'b0001, 1'b0};
        ev[6] = '{4'b0000, 1'b0};

        #2 rst = 1'b0;
        #2 chk_zero_outputs("reset");
        step;
        step;
        rst = 1'b1;
        step;

        // single-word latency, one channel at a time; other lanes carry decoy data
        foreach (sw[i]) begin
            in_data = {CH{~sw[i].data}};
            in_data[sw[i].ch*W +: W] = sw[i].data;
            in_stb = '0;
            in_stb[sw[i].ch] = 1'b1;
            chk("sw_ack_cycle0", in_ack, 0);
            step;
            chk("sw_ack_cycle1", in_ack, sw[i].exp_ack);
            chk("sw_out_stb_cycle1", out_stb, 0);
            step;
            in_stb = '0;
            chk("sw_out_stb_cycle2", out_stb, 1);
            chk("sw_out_data", out_data, sw[i].exp_data);
            chk("sw_out_channel", out_channel, sw[i].exp_ch);
            chk("sw_ack_cycle2", in_ack, 0);
            out_ack = 1'b1;
            step;
            out_ack = 1'b0;
            chk("sw_popped", out_stb, 0);
        end

        // round robin with every channel requesting and the consumer always ready
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = 32'hC0 + k;
        in_stb = 4'b1111;
        out_ack = 1'b1;
        multi = 0;
        for (int k = 0; k < 40 && q.size() < 6; k++) begin
            step;
            if ($countones(in_ack) > 1) multi++;
            if (out_stb) begin
                q.push_back(int'(out_channel));
                chk("rr_data_tag", out_data, 32'hC0 + out_channel);
            end
        end
        chk("rr_words", q.size(), 6);
        for (int j = 0; j < q.size(); j++) chk("rr_order", q[j], j % 4);
        chk("rr_multi_hot", multi, 0);
        in_stb = '0;
        repeat (6) step;
        chk("rr_drained", out_stb, 0);

        // backpressure: four words fill the buffer, no fifth grant
        out_ack = 1'b0;
        in_stb = 4'b1111;
        acks = 0;
        repeat (20) begin
            step;
            acks += $countones(in_ack);
        end
        chk("bp_acks", acks, 4);
        chk("bp_out_stb", out_stb, 1);
        out_ack = 1'b1;
        step;
        out_ack = 1'b0;
        chk("bp_no_same_cycle_grant", in_ack, 0);
        step;
        chk("bp_next_grant", $countones(in_ack), 1);
        in_stb = '0;
        out_ack = 1'b1;
        repeat (8) step;
        chk("bp_drained", out_stb, 0);

        // reset during ACCEPT with two words buffered
        out_ack = 1'b0;
        in_stb = 4'b1110;
        repeat (5) step;
        chk("rst_mid_in_accept", $countones(in_ack), 1);
        chk("rst_mid_buffered", out_stb, 1);
        #1 rst = 1'b0;
        #1 chk_zero_outputs("rst_mid");
        in_stb = 4'b1111;
        rst = 1'b1;
        step;
        chk("rst_first_grant", in_ack, 4'b0001);
        chk("rst_fifo_empty", out_stb, 0);
        in_stb = '0;
        step;
        out_ack = 1'b1;
        repeat (4) step;
        out_ack = 1'b0;
        chk("rst_final_drain", out_stb, 0);

`ifdef STREAM_HUB_EXC_CAPTURE_EN
        exception_in = 4'b0110;
        step;
        chk("exc_set", exception, 1);
        chk("exc_src_first", exception_src, 1);
        exception_in = 4'b0000;
        step;
        chk("exc_sticky", exception, 1);
        chk("exc_src_hold", exception_src, 1);
        exception_in = 4'b1000;
        exception_clr = 1'b1;
        step;
        chk("exc_clr_set_wins", exception, 1);
        chk("exc_src_new", exception_src, 3);
        exception_in = 4'b0000;
        step;
        exception_clr = 1'b0;
        chk("exc_cleared", exception, 0);
        chk("exc_src_cleared", exception_src, 0);
`else
        // registered masked OR; channel 0 is masked off
        prev = 1'b0;
        foreach (ev[i]) begin
            exception_in = ev[i].exc;
            chk("exc_registered", exception, prev);
            step;
            chk("exc_value", exception, ev[i].exp);
            chk("exc_src_zero", exception_src, 0);
            prev = ev[i].exp;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
